adc124s051_responder: RTL and testbench
=======================================

Name: adc124s051_responder

Overview:
- Synthesizable SPI responder that emulates a 4-channel, 12-bit ADC124S051 converter.
- Lets the current-acquisition SPI master be looped back in hardware and in simulation without the physical ADC.
- Samples the master's CS_n/SCLK/MOSI in the system clock domain and captures the channel address on the 3rd-5th rising SCLK edges.
- Shifts out 4 leading zeros plus 12 data bits MSB-first. Each frame returns the channel selected in the previous frame.

Parameters:
- DATA_W, 12, converter sample width
- FRAME_BITS, 16, SCLK edges per complete frame
- SYNC_STAGES, 2, synchronizer depth on iCS_n/iSCLK/iMOSI (min 2)

Ports:
- iClk  input  1  system clock
- iRst_n  input  1  asynchronous active-low reset
- iCS_n  input  1  chip select from SPI master, active low
- iSCLK  input  1  serial clock from master, idles high
- iMOSI  input  1  control word from master (DIN)
- oMISO  output  1  serial data to master (DOUT)
- iCh0_data..iCh3_data  input  DATA_W each  emulated channel values
- oChannel  output  2  channel whose value the current/next frame returns
- oFrame_done  output  1  one-cycle pulse after a complete frame
- oFrame_err  output  1  one-cycle pulse after an aborted frame (only with ADC_RESP_ERRCHK_EN)

Behaviour:
- Clock and reset: one clock, iClk. iRst_n is asynchronous, active-low.
- Reset values: oMISO=0, oChannel=0, oFrame_done=0, oFrame_err=0, bit counter=0, address shift=0, state=IDLE.
- Input sync: iCS_n, iSCLK and iMOSI each pass through SYNC_STAGES flops. Rise/fall of CS and SCLK are detected from the last stage against one extra delayed copy.
- Edge latency: oMISO updates SYNC_STAGES+1 iClk cycles after the pin edge.
  - Master SCLK half-period must be at least SYNC_STAGES+2 iClk cycles.
  - Slower masters are handled; faster masters are unsupported.
- State IDLE: oMISO=0. On CS fall go to SHIFT, then:
  - clear bit counter;
  - load 16-bit shift register = {4'b0, selected channel data}, selected channel = oChannel;
  - oMISO = shift[15].
- State SHIFT, rising SCLK:
  - increment bit counter, saturating at FRAME_BITS;
  - at counter values 2, 3, 4 before increment, shift the synchronized MOSI into addr[2:0] (ADD2 first). Only addr[1:0] selects the channel; ADD2 is ignored.
- State SHIFT, falling SCLK:
  - shift register left by one, fill 0; oMISO = new shift[15];
  - the first falling edge after CS fall is ignored when the counter is 0 (SCLK idles high).
- Counter at FRAME_BITS: further SCLK edges keep oMISO=0, and the counter stays saturated.
- CS rise, counter == FRAME_BITS: oChannel <= addr[1:0], oFrame_done pulses 1 cycle, return to IDLE.
- CS rise, counter < FRAME_BITS (abort): oChannel unchanged, addr discarded, oFrame_err pulses 1 cycle if enabled, return to IDLE.
- Simultaneous CS rise and SCLK edge in the same sync cycle: CS rise wins; the SCLK edge is ignored.
- Channel data: sampled only at CS fall. Input changes mid-frame do not affect the frame in flight.
- Reset mid-frame: immediate return to IDLE with reset values; the next frame returns channel 0.

Optional Feature:
- Macro ADC_RESP_ERRCHK_EN.
- Defined:
  - oFrame_err pulses on aborted frames;
  - an internal 8-bit saturating abort counter exists, observable in simulation only.
- Undefined: oFrame_err is tied to 0 and no counter logic is built.
- oFrame_done behaviour is identical in both builds.

Decomposition:
- Package adc124_pkg holds:
  - FRAME_BITS=16 and the lead-zero count 4;
  - address capture edge indices 2..4;
  - channel index width 2;
  - the state encoding IDLE/SHIFT.
- One natural sub-module: spi_sync_edge (SYNC_STAGES synchronizer + rise/fall detector). It is instantiated for CS and SCLK; MOSI uses the synchronizer only.

Test Plan:
- Reset, then frame with MOSI address 001, Ch0=0xABC: MISO returns 0x0ABC; oChannel=1 after CS rise; oFrame_done pulses once.
- Next frame, address 011, Ch1=0x123, Ch3=0xFFF: returns 0x0123; oChannel becomes 3. The following frame returns 0x0FFF.
- Abort: CS rises after 7 SCLK rising edges with address 010 while oChannel=3: oChannel stays 3; no oFrame_done; oFrame_err pulses (ERRCHK build) or stays 0 (default build).
- Ch0 changes 0x555→0xAAA mid-frame: the frame still returns 0x0555.
- 18 SCLK edges in one CS window: bits 16-17 on MISO are 0; frame counted valid; oFrame_done pulses once.
- iRst_n asserted at edge 9 of a frame: oMISO=0 immediately; the next full frame returns Ch0 data; oChannel=0 until that frame completes.

Source files
------------

// File: rtl/adc124_pkg.sv
// Shared constants and state encoding for the ADC124S051 SPI responder.
package adc124_pkg;

   localparam int ADC_FRAME_BITS = 16;
   localparam int ADC_LEAD_ZEROS = 4;
   localparam int ADC_ADDR_FIRST = 2;
   localparam int ADC_ADDR_LAST  = 4;
   localparam int ADC_CH_W       = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

endpackage

// File: rtl/adc124s051_responder_sync.sv
// Multi-stage synchronizer with rise/fall detection on the last stage.
module spi_sync_edge
   import adc124_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b1
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         dly_q  <= RST_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         dly_q  <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise_o = sync_q[SYNC_STAGES-1] & ~dly_q;
   assign fall_o = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/adc124s051_responder.sv
// SPI responder emulating a 4-channel 12-bit ADC124S051; each frame returns the
// channel addressed in the previous frame. ADC_RESP_ERRCHK_EN enables abort reporting.
module adc124s051_responder
   import adc124_pkg::*;
#(
   parameter int DATA_W      = ADC_FRAME_BITS - ADC_LEAD_ZEROS,
   parameter int FRAME_BITS  = ADC_FRAME_BITS,
   parameter int SYNC_STAGES = 2
) (
   input  logic              iClk,
   input  logic              iRst_n,
   input  logic              iCS_n,
   input  logic              iSCLK,
   input  logic              iMOSI,
   output logic              oMISO,
   input  logic [DATA_W-1:0] iCh0_data,
   input  logic [DATA_W-1:0] iCh1_data,
   input  logic [DATA_W-1:0] iCh2_data,
   input  logic [DATA_W-1:0] iCh3_data,
   output logic [1:0]        oChannel,
   output logic              oFrame_done,
   output logic              oFrame_err
);

   localparam int CNT_W = $clog2(FRAME_BITS + 1);
   localparam int PAD_W = FRAME_BITS - DATA_W;
   localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_ADDR_LO = CNT_W'(ADC_ADDR_FIRST);
   localparam logic [CNT_W-1:0] CNT_ADDR_HI = CNT_W'(ADC_ADDR_LAST);

   state_e                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [FRAME_BITS-1:0]   shift_q;
   logic [ADC_CH_W-1:0]     addr_q;
   logic [ADC_CH_W-1:0]     channel_q;
   logic                    miso_q;
   logic                    done_q;
   logic [SYNC_STAGES-1:0]  mosi_sync_q;
   logic                    cs_rise, cs_fall, sclk_rise, sclk_fall;
   logic [DATA_W-1:0]       sel_data;
   logic [FRAME_BITS-1:0]   load_word;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
      .clk_i   (iClk),
      .rst_n_i (iRst_n),
      .d_i     (iCS_n),
      .rise_o  (cs_rise),
      .fall_o  (cs_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
      .clk_i   (iClk),
      .rst_n_i (iRst_n),
      .d_i     (iSCLK),
      .rise_o  (sclk_rise),
      .fall_o  (sclk_fall)
   );

   // Same depth as CS/SCLK so MOSI stays aligned with the detected SCLK edge.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) mosi_sync_q <= '0;
      else         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], iMOSI};
   end

   always_comb begin
      sel_data = iCh0_data;
      case (channel_q)
         2'd1:    sel_data = iCh1_data;
         2'd2:    sel_data = iCh2_data;
         2'd3:    sel_data = iCh3_data;
         default: sel_data = iCh0_data;
      endcase
   end

   assign load_word = {{PAD_W{1'b0}}, sel_data};

`ifdef ADC_RESP_ERRCHK_EN
   logic       err_q;
   logic [7:0] abort_cnt_q;
`endif

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         shift_q   <= '0;
         addr_q    <= '0;
         channel_q <= '0;
         miso_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef ADC_RESP_ERRCHK_EN
         err_q     <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef ADC_RESP_ERRCHK_EN
         err_q  <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               miso_q <= 1'b0;
               if (cs_fall) begin
                  state_q <= ST_SHIFT;
                  cnt_q   <= '0;
                  addr_q  <= '0;
                  shift_q <= load_word;
                  miso_q  <= load_word[FRAME_BITS-1];
               end
            end
            ST_SHIFT: begin
               // CS rise takes priority over any coincident SCLK edge.
               if (cs_rise) begin
                  state_q <= ST_IDLE;
                  miso_q  <= 1'b0;
                  if (cnt_q == CNT_FULL) begin
                     channel_q <= addr_q;
                     done_q    <= 1'b1;
                  end else begin
`ifdef ADC_RESP_ERRCHK_EN
                     err_q <= 1'b1;
`endif
                  end
               end else if (sclk_rise) begin
                  if (cnt_q != CNT_FULL) cnt_q <= cnt_q + 1'b1;
                  // ADD2 shifts out the top of the 2-bit register and is dropped.
                  if (cnt_q >= CNT_ADDR_LO && cnt_q <= CNT_ADDR_HI)
                     addr_q <= {addr_q[0], mosi_sync_q[SYNC_STAGES-1]};
               end else if (sclk_fall) begin
                  if (cnt_q == CNT_FULL) begin
                     miso_q <= 1'b0;
                  end else if (cnt_q != '0) begin
                     shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
                     miso_q  <= shift_q[FRAME_BITS-2];
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef ADC_RESP_ERRCHK_EN
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n)                             abort_cnt_q <= '0;
      else if (err_q && abort_cnt_q != 8'hFF)  abort_cnt_q <= abort_cnt_q + 8'd1;
   end
   assign oFrame_err = err_q;
`else
   assign oFrame_err = 1'b0;
`endif

   assign oMISO       = miso_q;
   assign oChannel    = channel_q;
   assign oFrame_done = done_q;

endmodule

// File: tb/tb_adc124s051_responder.sv
// Self-checking bench for adc124s051_responder: a bit-banged SPI master against a frame-level model.
module tb_adc124s051_responder;

   logic        clk;
   logic        rst_n;
   logic        cs_n;
   logic        sclk;
   logic        mosi;
   logic        miso;
   logic [11:0] ch_d [4];
   logic [1:0]  channel;
   logic        frame_done;
   logic        frame_err;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int model_ch = 0;

`ifdef ADC_RESP_ERRCHK_EN
   localparam int ERR_ON = 1;
`else
   localparam int ERR_ON = 0;
`endif
   localparam int HALF = 6;

   adc124s051_responder dut (
      .iClk        (clk),
      .iRst_n      (rst_n),
      .iCS_n       (cs_n),
      .iSCLK       (sclk),
      .iMOSI       (mosi),
      .oMISO       (miso),
      .iCh0_data   (ch_d[0]),
      .iCh1_data   (ch_d[1]),
      .iCh2_data   (ch_d[2]),
      .iCh3_data   (ch_d[3]),
      .oChannel    (channel),
      .oFrame_done (frame_done),
      .oFrame_err  (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (frame_done) done_cnt <= done_cnt + 1;
      if (frame_err)  err_cnt  <= err_cnt + 1;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Bits the master should see after n SCLK periods: the 16-bit word, then zeros.
   function automatic logic [31:0] exp_bits(input logic [15:0] word, input int n);
      if (n >= 16) return 32'(word) << (n - 16);
      return 32'(word) >> (16 - n);
   endfunction

   function automatic logic [15:0] model_word();
      return {4'b0000, ch_d[model_ch]};
   endfunction

   function automatic void model_frame_end(input logic [2:0] addr, input int n);
      if (n >= 16) model_ch = int'(addr[1:0]);
   endfunction

   // Master: SCLK idles high, MOSI changes on falling edges, MISO sampled just before rising edges.
   task automatic do_frame(input logic [2:0] addr, input int nedges, input int chg_edge,
                           input logic [11:0] chg_val, input int rst_edge,
                           output logic [31:0] cap, output int dn, output int er);
      logic [15:0] ctrl;
      int d0, e0;
      ctrl = 16'($urandom);
      ctrl[13] = addr[2];
      ctrl[12] = addr[1];
      ctrl[11] = addr[0];
      cap = '0;
      d0 = done_cnt;
      e0 = err_cnt;
      cs_n = 1'b0;
      wait_clk(HALF);
      for (int i = 0; i < nedges; i++) begin
         if (i == rst_edge) begin
            dn = done_cnt - d0;
            er = err_cnt - e0;
            return;
         end
         if (i == chg_edge) ch_d[0] = chg_val;
         sclk = 1'b0;
         mosi = (i < 16) ? ctrl[15-i] : 1'($urandom);
         wait_clk(HALF);
         cap = {cap[30:0], miso};
         sclk = 1'b1;
         wait_clk(HALF);
      end
      cs_n = 1'b1;
      wait_clk(10);
      dn = done_cnt - d0;
      er = err_cnt - e0;
   endtask

   task automatic test_reset();
      n_checks++;
      if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso got %b want 0", miso); end
      n_checks++;
      if (channel !== 2'd0) begin n_fail++; $display("FAIL reset_channel got %0d want 0", channel); end
      n_checks++;
      if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", frame_done); end
      n_checks++;
      if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", frame_err); end
   endtask

   task automatic test_basic();
      logic [31:0] cap, exp;
      int dn, er;
      ch_d[0] = 12'hABC;
      exp = exp_bits(model_word(), 16);
      do_frame(3'b001, 16, -1, 12'h0, -1, cap, dn, er);
      model_frame_end(3'b001, 16);
      n_checks++;
      if (cap !== exp) begin n_fail++; $display("FAIL basic_data got %h want %h", cap, exp); end
      n_checks++;
      if (exp !== 32'h0ABC) begin n_fail++; $display("FAIL basic_model got %h want 0ABC", exp); end
      n_checks++;
      if (int'(channel) !== model_ch) begin n_fail++; $display("FAIL basic_channel got %0d want %0d", channel, model_ch); end
      n_checks++;
      if (dn !== 1) begin n_fail++; $display("FAIL basic_done got %0d want 1", dn); end
      n_checks++;
      if (er !== 0) begin n_fail++; $display("FAIL basic_err got %0d want 0", er); end
   endtask

   task automatic test_switch();
      logic [31:0] cap, exp;
      int dn, er;
      ch_d[1] = 12'h123;
      ch_d[3] = 12'hFFF;
      exp = exp_bits(model_word(), 16);
      do_frame(3'b011, 16, -1, 12'h0, -1, cap, dn, er);
      model_frame_end(3'b011, 16);
      n_checks++;
      if (cap !== 32'h0123 || exp !== 32'h0123) begin n_fail++; $display("FAIL switch_data1 got %h want %h", cap, exp); end
      n_checks++;
      if (channel !== 2'd3) begin n_fail++; $display("FAIL switch_channel got %0d want 3", channel); end
      exp = exp_bits(model_word(), 16);
      do_frame(3'b111, 16, -1, 12'h0, -1, cap, dn, er);
      model_frame_end(3'b111, 16);
      n_checks++;
      if (cap !== exp) begin n_fail++; $display("FAIL switch_data2 got %h want %h", cap, exp); end
      n_checks++;
      if (int'(channel) !== model_ch || dn !== 1) begin
         n_fail++; $display("FAIL switch_end got ch %0d done %0d want ch %0d done 1", channel, dn, model_ch);
      end
   endtask

   task automatic test_abort();
      logic [31:0] cap, exp;
      int dn, er;
      exp = exp_bits(model_word(), 7);
      do_frame(3'b010, 7, -1, 12'h0, -1, cap, dn, er);
      model_frame_end(3'b010, 7);
      n_checks++;
      if (cap !== exp) begin n_fail++; $display("FAIL abort_data got %h want %h", cap, exp); end
      n_checks++;
      if (channel !== 2'd3) begin n_fail++; $display("FAIL abort_channel got %0d want 3", channel); end
      n_checks++;
      if (dn !== 0) begin n_fail++; $display("FAIL abort_done got %0d want 0", dn); end
      n_checks++;
      if (er !== ERR_ON) begin n_fail++; $display("FAIL abort_err got %0d want %0d", er, ERR_ON); end
   endtask

   task automatic test_midframe_change();
      logic [31:0] cap, exp;
      int dn, er;
      exp = exp_bits(model_word(), 16);
      do_frame(3'b000, 16, -1, 12'h0, -1, cap, dn, er);
      model_frame_end(3'b000, 16);
      n_checks++;
      if (cap !== exp) begin n_fail++; $display("FAIL chg_pre_data got %h want %h", cap, exp); end
      ch_d[0] = 12'h555;
      exp = exp_bits(model_word(), 16);
      do_frame(3'b000, 16, 8, 12'hAAA, -1, cap, dn, er);
      model_frame_end(3'b000, 16);
      n_checks++;
      if (cap !== 32'h0555 || exp !== 32'h0555) begin n_fail++; $display("FAIL chg_data got %h want %h", cap, exp); end
   endtask

   task automatic test_overlong();
      logic [31:0] cap, exp;
      int dn, er;
      exp = exp_bits(model_word(), 18);
      do_frame(3'b010, 18, -1, 12'h0, -1, cap, dn, er);
      model_frame_end(3'b010, 18);
      n_checks++;
      if (cap !== exp) begin n_fail++; $display("FAIL long_data got %h want %h", cap, exp); end
      n_checks++;
      if (cap[1:0] !== 2'b00) begin n_fail++; $display("FAIL long_tail got %b want 00", cap[1:0]); end
      n_checks++;
      if (dn !== 1 || er !== 0) begin n_fail++; $display("FAIL long_pulses got done %0d err %0d want 1 0", dn, er); end
      n_checks++;
      if (int'(channel) !== model_ch) begin n_fail++; $display("FAIL long_channel got %0d want %0d", channel, model_ch); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] cap, exp;
      int dn, er;
      ch_d[2] = 12'($urandom);
      do_frame(3'b001, 16, -1, 12'h0, 9, cap, dn, er);
      @(negedge clk);
      rst_n = 1'b0;
      cs_n  = 1'b1;
      sclk  = 1'b1;
      #1;
      n_checks++;
      if (miso !== 1'b0) begin n_fail++; $display("FAIL rstmid_miso got %b want 0", miso); end
      n_checks++;
      if (channel !== 2'd0) begin n_fail++; $display("FAIL rstmid_channel got %0d want 0", channel); end
      model_ch = 0;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(5);
      ch_d[0] = 12'($urandom);
      exp = exp_bits(model_word(), 16);
      do_frame(3'b011, 16, -1, 12'h0, -1, cap, dn, er);
      model_frame_end(3'b011, 16);
      n_checks++;
      if (cap !== exp) begin n_fail++; $display("FAIL rstmid_data got %h want %h", cap, exp); end
      n_checks++;
      if (int'(channel) !== model_ch || dn !== 1) begin
         n_fail++; $display("FAIL rstmid_end got ch %0d done %0d want ch %0d done 1", channel, dn, model_ch);
      end
   endtask

   task automatic test_random();
      logic [31:0] cap, exp;
      logic [2:0]  addr;
      int dn, er, n, edn, eer;
      for (int k = 0; k < 10; k++) begin
         for (int c = 0; c < 4; c++) ch_d[c] = 12'($urandom);
         addr = 3'($urandom);
         n = (($urandom % 4) == 0) ? int'($urandom_range(5, 15)) : int'($urandom_range(16, 20));
         exp = exp_bits(model_word(), n);
         edn = (n >= 16) ? 1 : 0;
         eer = (n >= 16) ? 0 : ERR_ON;
         do_frame(addr, n, -1, 12'h0, -1, cap, dn, er);
         model_frame_end(addr, n);
         n_checks++;
         if (cap !== exp) begin n_fail++; $display("FAIL rand_data[%0d] n=%0d got %h want %h", k, n, cap, exp); end
         n_checks++;
         if (int'(channel) !== model_ch) begin n_fail++; $display("FAIL rand_channel[%0d] got %0d want %0d", k, channel, model_ch); end
         n_checks++;
         if (dn !== edn || er !== eer) begin
            n_fail++; $display("FAIL rand_pulses[%0d] got done %0d err %0d want %0d %0d", k, dn, er, edn, eer);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      cs_n  = 1'b1;
      sclk  = 1'b1;
      mosi  = 1'b0;
      for (int c = 0; c < 4; c++) ch_d[c] = '0;
      wait_clk(4);
      test_reset();
      rst_n = 1'b1;
      wait_clk(4);
      test_basic();
      test_switch();
      test_abort();
      test_midframe_change();
      test_overlong();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
